// File: rtl/lui_addi_fuser.sv
// ---------------------------------------------------------------------------
// lui_addi_fuser
//
// Decode-side macro-op fusion between fetch and the register stage. A
// "LUI rd" is held in a one-entry candidate register for up to FUSE_WAIT
// idle cycles; if the next accepted instruction is "ADDI rd, rd, imm" the
// pair leaves as one fused micro-op carrying the finished XLEN-bit constant,
// so the register stage can drive Imm directly. Everything else passes
// through a one-entry output register with valid/ready on both sides.
//
// Ports
//   clk        clock
//   reset_n    synchronous active-low reset
//   in_valid   fetch offers an instruction
//   in_ready   block accepts this cycle (transfer on in_valid && in_ready)
//   in_instr   32-bit instruction word
//   in_pc      instruction PC (XLEN bits)
//   flush      synchronous squash (redirect / trap)
//   out_valid  output register holds a micro-op
//   out_ready  decode stage accepts
//   out_instr  instruction word; the LUI word when fused
//   out_pc     PC; the LUI PC when fused
//   out_fused  micro-op is a fused LUI+ADDI
//   out_imm    fused constant; zero when not fused
//   out_rd     destination register, out_instr[11:7]
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 64
`endif

module lui_addi_fuser #(
  parameter int XLEN      = `XLEN,
  parameter int FUSE_WAIT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fused,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd
);

  localparam int               CNT_W    = $clog2(FUSE_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FUSE_WAIT - 1);
  localparam logic [6:0]       OPC_LUI  = 7'b0110111;
  localparam logic [6:0]       OPC_OPIMM = 7'b0010011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // candidate register unused
    ST_CAND  = 2'd1,  // candidate register holds a LUI awaiting its ADDI
    ST_DRAIN = 2'd2   // candidate register holds a non-LUI that must go out next
  } state_e;

  // LUI with a non-zero destination: worth holding back for a partner.
  function automatic logic is_lui_cand(input logic [31:0] w);
    return (w[6:0] == OPC_LUI) && (w[11:7] != 5'd0);
  endfunction

  // ADDI whose rd and rs1 both name the held LUI's destination.
  function automatic logic is_match(input logic [31:0] w, input logic [4:0] cand_rd);
    return (w[6:0] == OPC_OPIMM) && (w[14:12] == 3'b000) &&
           (w[11:7] == cand_rd) && (w[19:15] == cand_rd);
  endfunction

  // Both halves are sign-extended to the full datapath before the add, so on
  // RV64 the result is the true 64-bit sum with no 32-bit wrap.
  function automatic logic [XLEN-1:0] fused_imm(input logic [31:0] lui_w,
                                                input logic [31:0] addi_w);
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    hi = XLEN'($signed({lui_w[31:12], 12'h000}));
    lo = XLEN'($signed(addi_w[31:20]));
    return hi + lo;
  endfunction

  state_e            state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [31:0]       c_instr_q, c_instr_d;
  logic [XLEN-1:0]   c_pc_q,    c_pc_d;
  logic              o_valid_q, o_valid_d;
  logic [31:0]       o_instr_q, o_instr_d;
  logic [XLEN-1:0]   o_pc_q,    o_pc_d;
  logic              o_fused_q, o_fused_d;
  logic [XLEN-1:0]   o_imm_q,   o_imm_d;

  logic o_free_s;
  logic in_ready_s;
  logic accept_s;

  assign o_free_s = !o_valid_q || out_ready;
  assign accept_s = in_valid && in_ready_s;

  // Input handshake: only when the output slot can take whatever this accept produces.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      ST_EMPTY, ST_CAND: in_ready_s = o_free_s && !flush && reset_n;
      ST_DRAIN:          in_ready_s = 1'b0;
      default:           in_ready_s = 1'b0;
    endcase
  end

  // Next-state and datapath selection for the candidate and output registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    c_instr_d = c_instr_q;
    c_pc_d    = c_pc_q;
    o_instr_d = o_instr_q;
    o_pc_d    = o_pc_q;
    o_fused_d = o_fused_q;
    o_imm_d   = o_imm_q;
    // A free output slot empties unless something is loaded below.
    if (o_free_s) begin
      o_valid_d = 1'b0;
    end else begin
      o_valid_d = o_valid_q;
    end

    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          if (is_lui_cand(in_instr)) begin
            c_instr_d = in_instr;
            c_pc_d    = in_pc;
            cnt_d     = {CNT_W{1'b0}};
            state_d   = ST_CAND;
          end else begin
            o_valid_d = 1'b1;
            o_instr_d = in_instr;
            o_pc_d    = in_pc;
            o_fused_d = 1'b0;
            o_imm_d   = {XLEN{1'b0}};
          end
        end else begin
          state_d = ST_EMPTY;
        end
      end

      ST_CAND: begin
        if (accept_s) begin
          if (is_match(in_instr, c_instr_q[11:7])) begin
            o_valid_d = 1'b1;
            o_instr_d = c_instr_q;
            o_pc_d    = c_pc_q;
            o_fused_d = 1'b1;
            o_imm_d   = fused_imm(c_instr_q, in_instr);
            cnt_d     = {CNT_W{1'b0}};
            state_d   = ST_EMPTY;
          end else begin
            // The held LUI leaves alone; the newcomer takes its place.
            o_valid_d = 1'b1;
            o_instr_d = c_instr_q;
            o_pc_d    = c_pc_q;
            o_fused_d = 1'b0;
            o_imm_d   = {XLEN{1'b0}};
            c_instr_d = in_instr;
            c_pc_d    = in_pc;
            cnt_d     = {CNT_W{1'b0}};
            if (is_lui_cand(in_instr)) begin
              state_d = ST_CAND;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          // Wait exhausted: release as soon as the output slot frees up.
          if (o_free_s) begin
            o_valid_d = 1'b1;
            o_instr_d = c_instr_q;
            o_pc_d    = c_pc_q;
            o_fused_d = 1'b0;
            o_imm_d   = {XLEN{1'b0}};
            cnt_d     = {CNT_W{1'b0}};
            state_d   = ST_EMPTY;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DRAIN: begin
        if (o_free_s) begin
          o_valid_d = 1'b1;
          o_instr_d = c_instr_q;
          o_pc_d    = c_pc_q;
          o_fused_d = 1'b0;
          o_imm_d   = {XLEN{1'b0}};
          state_d   = ST_EMPTY;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_EMPTY;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers: reset clears everything, flush squashes O and C only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_EMPTY;
      cnt_q     <= {CNT_W{1'b0}};
      c_instr_q <= 32'd0;
      c_pc_q    <= {XLEN{1'b0}};
      o_valid_q <= 1'b0;
      o_instr_q <= 32'd0;
      o_pc_q    <= {XLEN{1'b0}};
      o_fused_q <= 1'b0;
      o_imm_q   <= {XLEN{1'b0}};
    end else if (flush) begin
      state_q   <= ST_EMPTY;
      cnt_q     <= {CNT_W{1'b0}};
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      c_instr_q <= c_instr_d;
      c_pc_q    <= c_pc_d;
      o_valid_q <= o_valid_d;
      o_instr_q <= o_instr_d;
      o_pc_q    <= o_pc_d;
      o_fused_q <= o_fused_d;
      o_imm_q   <= o_imm_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = o_valid_q;
  assign out_instr = o_instr_q;
  assign out_pc    = o_pc_q;
  assign out_fused = o_fused_q;
  assign out_imm   = o_imm_q;
  assign out_rd    = o_instr_q[11:7];

endmodule

// File: tb/tb_lui_addi_fuser.sv
// Testbench for lui_addi_fuser (XLEN = 64, FUSE_WAIT = 2).
module tb_lui_addi_fuser;
  localparam int XLEN = 64;
  localparam int FW   = 2;

  logic            clk = 1'b0;
  logic            reset_n, in_valid, in_ready, flush;
  logic            out_valid, out_ready, out_fused;
  logic [31:0]     in_instr, out_instr;
  logic [XLEN-1:0] in_pc, out_pc, out_imm;
  logic [4:0]      out_rd;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        fused;
    logic [63:0] imm;
  } uop_t;

  lui_addi_fuser #(.XLEN(XLEN), .FUSE_WAIT(FW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_fused(out_fused), .out_imm(out_imm), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] enc_opimm(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [2:0] f3, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_op(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [2:0] f3);
    return {7'b0000000, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Value a LUI/ADDI pair leaves in rd on RV64, as plain signed arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] lui_w, input logic [31:0] addi_w);
    logic signed [31:0] hi32;
    logic signed [11:0] lo12;
    longint hv;
    longint lv;
    hi32 = {lui_w[31:12], 12'h000};
    lo12 = addi_w[31:20];
    hv = hi32;
    lv = lo12;
    return 64'(hv + lv);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = enc_op(5'd1, 5'd2, 5'd3, 3'b000); in_pc = 64'h10;
    repeat (2) step();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++;
    if ({out_valid, out_fused, out_instr, out_pc, out_imm, out_rd} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%b f=%b i=%h pc=%h imm=%h rd=%0d want all 0",
               out_valid, out_fused, out_instr, out_pc, out_imm, out_rd);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    logic [31:0] w0, w1;
    w0 = enc_opimm(5'd5, 5'd0, 3'b000, 12'd3);
    w1 = enc_op(5'd6, 5'd5, 5'd5, 3'b000);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = w0; in_pc = 64'h100;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL pass_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_instr = w1; in_pc = 64'h104;
    n_checks++;
    if ({out_valid, out_fused, out_instr, out_pc, out_imm, out_rd} !== {1'b1, 1'b0, w0, 64'h100, 64'h0, 5'd5}) begin
      n_errors++; $display("FAIL pass_first: got v=%b f=%b i=%h pc=%h imm=%h want addi at 100", out_valid, out_fused, out_instr, out_pc, out_imm);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_fused, out_instr, out_pc, out_imm} !== {1'b1, 1'b0, w1, 64'h104, 64'h0}) begin
      n_errors++; $display("FAIL pass_second: got v=%b f=%b i=%h pc=%h imm=%h want add at 104", out_valid, out_fused, out_instr, out_pc, out_imm);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL pass_idle: got valid=%b want 0", out_valid); end
  endtask

  // Adjacent LUI/ADDI pair; expects one fused output the cycle after the ADDI.
  task automatic test_fusion(input logic [31:0] wl, input logic [31:0] wa,
                             input logic [63:0] pc, input logic [63:0] exp_imm);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = wl; in_pc = pc;
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL fuse_hold: got valid=%b want 0", out_valid); end
    in_instr = wa; in_pc = pc + 64'd4;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_fused, out_instr, out_pc, out_imm, out_rd} !== {1'b1, 1'b1, wl, pc, exp_imm, wl[11:7]}) begin
      n_errors++; $display("FAIL fuse_out: got v=%b f=%b i=%h pc=%h imm=%h rd=%0d want fused imm=%h pc=%h",
                           out_valid, out_fused, out_instr, out_pc, out_imm, out_rd, exp_imm, pc);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL fuse_idle: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_rd_mismatch();
    logic [31:0] wl, wm;
    wl = enc_lui(5'd1, 20'h80000);
    wm = enc_opimm(5'd2, 5'd1, 3'b000, 12'd1);
    in_valid = 1'b1; in_instr = wl; in_pc = 64'h3000;
    step();
    in_instr = wm; in_pc = 64'h3004;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_fused, out_instr, out_pc, out_imm} !== {1'b1, 1'b0, wl, 64'h3000, 64'h0}) begin
      n_errors++; $display("FAIL mismatch_lui: got v=%b f=%b i=%h pc=%h imm=%h want lone lui", out_valid, out_fused, out_instr, out_pc, out_imm);
    end
    step();
    n_checks++;
    if ({out_valid, out_fused, out_instr, out_pc, out_imm} !== {1'b1, 1'b0, wm, 64'h3004, 64'h0}) begin
      n_errors++; $display("FAIL mismatch_addi: got v=%b f=%b i=%h pc=%h imm=%h want addi", out_valid, out_fused, out_instr, out_pc, out_imm);
    end
    step();
  endtask

  task automatic test_timeout();
    logic [31:0] wl, la, lb;
    wl = enc_lui(5'd7, 20'hABCDE);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = wl; in_pc = 64'h4000;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < FW; k++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL timeout_early: cycle %0d got valid=%b want 0", k + 1, out_valid); end
      step();
    end
    n_checks++;
    if ({out_valid, out_fused, out_instr, out_pc, out_imm} !== {1'b1, 1'b0, wl, 64'h4000, 64'h0}) begin
      n_errors++; $display("FAIL timeout_release: got v=%b f=%b i=%h pc=%h want lone lui at accept+3", out_valid, out_fused, out_instr, out_pc);
    end
    step();
    // Stall with O occupied while C holds a second LUI.
    la = enc_lui(5'd8, 20'h00011);
    lb = enc_lui(5'd9, 20'h00022);
    in_valid = 1'b1; in_instr = la; in_pc = 64'h5000;
    step();
    in_instr = lb; in_pc = 64'h5004;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({out_valid, out_instr} !== {1'b1, la}) begin
        n_errors++; $display("FAIL stall_hold: cycle %0d got v=%b i=%h want %h", k, out_valid, out_instr, la);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if ({out_valid, out_fused, out_instr, out_pc} !== {1'b1, 1'b0, lb, 64'h5004}) begin
      n_errors++; $display("FAIL stall_release: got v=%b f=%b i=%h pc=%h want %h", out_valid, out_fused, out_instr, out_pc, lb);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stall_idle: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] l3, l4, a4, orw, addw;
    l3 = enc_lui(5'd3, 20'h00001);
    l4 = enc_lui(5'd4, 20'h00004);
    a4 = enc_opimm(5'd4, 5'd4, 3'b000, 12'd8);
    orw = enc_op(5'd5, 5'd6, 5'd7, 3'b110);
    addw = enc_op(5'd6, 5'd5, 5'd5, 3'b000);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = l3; in_pc = 64'h6000;
    step();
    in_instr = l4; in_pc = 64'h6004;
    step();
    in_instr = a4; in_pc = 64'h6008;
    n_checks++;
    if ({out_valid, out_fused, out_instr, out_pc} !== {1'b1, 1'b0, l3, 64'h6000}) begin
      n_errors++; $display("FAIL b2b_lui3: got v=%b f=%b i=%h pc=%h want lone lui x3", out_valid, out_fused, out_instr, out_pc);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_fused, out_instr, out_pc, out_imm, out_rd} !== {1'b1, 1'b1, l4, 64'h6004, 64'h4008, 5'd4}) begin
      n_errors++; $display("FAIL b2b_fused: got v=%b f=%b i=%h pc=%h imm=%h want imm 4008", out_valid, out_fused, out_instr, out_pc, out_imm);
    end
    step();
    // LUI followed by OR: one cycle of DRAIN with in_ready low.
    in_valid = 1'b1; in_instr = l3; in_pc = 64'h7000;
    step();
    in_instr = orw; in_pc = 64'h7004;
    step();
    in_instr = addw; in_pc = 64'h7008;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL drain_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, out_instr, out_pc} !== {1'b1, orw, 64'h7004}) begin
      n_errors++; $display("FAIL drain_out: got v=%b i=%h pc=%h want or at 7004", out_valid, out_instr, out_pc);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL drain_ready_back: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_instr, out_pc} !== {1'b1, addw, 64'h7008}) begin
      n_errors++; $display("FAIL drain_next: got v=%b i=%h pc=%h want add at 7008", out_valid, out_instr, out_pc);
    end
    step();
  endtask

  task automatic test_flush();
    logic [31:0] wl, wa, orw;
    wl = enc_lui(5'd11, 20'h00001);
    wa = enc_opimm(5'd11, 5'd11, 3'b000, 12'd5);
    orw = enc_op(5'd5, 5'd6, 5'd7, 3'b110);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = wl; in_pc = 64'h8000;
    step();
    in_instr = wa; in_pc = 64'h8004; flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_cand: cycle %0d got valid=%b want 0", k, out_valid); end
      step();
    end
    // Candidate gone: the same ADDI now passes through unfused.
    in_valid = 1'b1; in_instr = wa; in_pc = 64'h8008;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_fused, out_instr, out_pc, out_imm} !== {1'b1, 1'b0, wa, 64'h8008, 64'h0}) begin
      n_errors++; $display("FAIL flush_empty: got v=%b f=%b i=%h pc=%h want unfused addi", out_valid, out_fused, out_instr, out_pc);
    end
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = orw; in_pc = 64'h8100;
    step();
    in_valid = 1'b0;
    step();
    n_checks++;
    if ({out_valid, out_instr} !== {1'b1, orw}) begin
      n_errors++; $display("FAIL flush_stalled_pre: got v=%b i=%h want %h", out_valid, out_instr, orw);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_stalled: got valid=%b want 0", out_valid); end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] wl, orw;
    wl = enc_lui(5'd12, 20'h00002);
    orw = enc_op(5'd5, 5'd6, 5'd7, 3'b110);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = wl; in_pc = 64'h9000;
    step();
    in_instr = orw; in_pc = 64'h9004;
    step();
    in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_drain_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, out_fused, out_instr, out_pc, out_imm, out_rd} !== '0) begin
      n_errors++; $display("FAIL rst_drain_outputs: got v=%b i=%h pc=%h imm=%h want all 0", out_valid, out_instr, out_pc, out_imm);
    end
    reset_n = 1'b1;
    repeat (3) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_drain_discard: got valid=%b want 0", out_valid); end
    end
  endtask

  // Continuous fetch stream with random back-pressure, checked in order
  // against a transaction-level fusion model.
  task automatic test_random();
    logic [31:0] prog[$];
    logic [63:0] pcs[$];
    uop_t        exp_q[$];
    uop_t        e;
    logic [31:0] w, pl;
    logic [63:0] ppc;
    logic        pend;
    int          idx, got, cyc;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: w = enc_lui(5'($urandom_range(0, 3)), 20'($urandom));
        1: begin
          w = enc_opimm(5'($urandom_range(0, 3)), 5'd0, 3'b000, 12'($urandom));
          w[19:15] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : w[11:7];
        end
        2: w = enc_opimm(5'($urandom_range(1, 3)), 5'($urandom_range(1, 3)),
                         ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b010, 12'($urandom));
        default: w = enc_op(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'b110);
      endcase
      prog.push_back(w);
      pcs.push_back(64'h1_0000 + 64'(4 * i));
    end
    pend = 1'b0; pl = 32'd0; ppc = 64'd0;
    for (int i = 0; i < prog.size(); i++) begin
      w = prog[i];
      if (pend) begin
        pend = 1'b0;
        if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000 &&
            w[11:7] == pl[11:7] && w[19:15] == pl[11:7]) begin
          exp_q.push_back('{instr: pl, pc: ppc, fused: 1'b1, imm: ref_imm(pl, w)});
          continue;
        end
        exp_q.push_back('{instr: pl, pc: ppc, fused: 1'b0, imm: 64'h0});
      end
      if (w[6:0] == 7'b0110111 && w[11:7] != 5'd0) begin
        pend = 1'b1; pl = w; ppc = pcs[i];
      end else begin
        exp_q.push_back('{instr: w, pc: pcs[i], fused: 1'b0, imm: 64'h0});
      end
    end
    if (pend) exp_q.push_back('{instr: pl, pc: ppc, fused: 1'b0, imm: 64'h0});

    idx = 0; got = 0; cyc = 0;
    while (got < exp_q.size() && cyc < 5000) begin
      in_valid = (idx < prog.size());
      if (idx < prog.size()) begin
        in_instr = prog[idx];
        in_pc = pcs[idx];
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        e = exp_q[got];
        n_checks++;
        if ({out_fused, out_instr, out_pc, out_imm, out_rd} !== {e.fused, e.instr, e.pc, e.imm, e.instr[11:7]}) begin
          n_errors++;
          $display("FAIL rand_uop[%0d]: got f=%b i=%h pc=%h imm=%h want f=%b i=%h pc=%h imm=%h",
                   got, out_fused, out_instr, out_pc, out_imm, e.fused, e.instr, e.pc, e.imm);
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got != exp_q.size()) begin
      n_errors++; $display("FAIL rand_count: got %0d outputs want %0d within budget", got, exp_q.size());
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rand_extra: got valid=%b want 0 after stream", out_valid); end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = 32'd0; in_pc = 64'd0;
    test_reset();
    test_passthrough();
    test_fusion(enc_lui(5'd10, 20'h12345), enc_opimm(5'd10, 5'd10, 3'b000, 12'hFFF),
                64'h2000, 64'h0000_0000_1234_4FFF);
    test_fusion(enc_lui(5'd1, 20'h80000), enc_opimm(5'd1, 5'd1, 3'b000, 12'h7FF),
                64'h2100, 64'hFFFF_FFFF_8000_07FF);
    test_rd_mismatch();
    test_timeout();
    test_back_to_back();
    test_flush();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
